br_predict: RTL and testbench
=============================

BR_PREDICT -- requirements
Module: br_predict

Interface
REQ-001 SHALL have parameter IDX_W, default 4, giving the branch-history-table index width; the table holds 2^IDX_W entries.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port pc_f_i, input, 32 bits: fetch-stage PC used for the prediction lookup.
REQ-005 SHALL have port pred_taken_o, output, 1 bit: combinational prediction for pc_f_i.
REQ-006 SHALL have port ex_valid_i, input, 1 bit: the execute-stage instruction is valid.
REQ-007 SHALL have port ex_is_br_i, input, 1 bit: the execute-stage instruction is a conditional branch.
REQ-008 SHALL have port ex_funct3_i, input, 3 bits: branch funct3.
REQ-009 SHALL have port ex_pc_i, input, 32 bits: PC of the execute-stage branch.
REQ-010 SHALL have port ex_target_i, input, 32 bits: computed branch target.
REQ-011 SHALL have port ex_pred_taken_i, input, 1 bit: the prediction carried down the pipe with the branch.
REQ-012 SHALL have port br_less_i, input, 1 bit: less-than result from the branch comparator.
REQ-013 SHALL have port br_equal_i, input, 1 bit: equal result from the branch comparator.
REQ-014 SHALL have port br_unsign_o, output, 1 bit: comparator mode select driven to the comparator.
REQ-015 SHALL have port taken_o, output, 1 bit: combinational resolved direction.
REQ-016 SHALL have port mispredict_o, output, 1 bit: combinational mispredict indication.
REQ-017 SHALL have port flush_o, output, 1 bit: registered one-cycle flush pulse.
REQ-018 SHALL have port redirect_pc_o, output, 32 bits: registered redirect PC, valid while flush_o is 1.
REQ-019 SHALL have port illegal_o, output, 1 bit: combinational flag for a branch with funct3 010 or 011.
REQ-020 SHALL have port br_cnt_o, output, 32 bits: count of resolved legal branches.
REQ-021 SHALL have port mispred_cnt_o, output, 32 bits: count of mispredicted branches.

Function
REQ-022 SHALL drive br_unsign_o = ex_funct3_i[1] combinationally, independent of valid.
REQ-023 SHALL define resolve = ex_valid_i & ex_is_br_i & legal, where legal means funct3 is not 010 and not 011.
REQ-024 SHALL decode taken_o when resolve is 1 as follows; taken_o SHALL be 0 otherwise.
- BEQ 000: br_equal_i
- BNE 001: !br_equal_i
- BLT 100 / BLTU 110: br_less_i
- BGE 101 / BGEU 111: !br_less_i
REQ-025 SHALL assert illegal_o = ex_valid_i & ex_is_br_i & !legal; an illegal branch updates nothing and never mispredicts.
REQ-026 SHALL hold a table of 2-bit saturating counters indexed by PC bits [IDX_W+1:2]; pred_taken_o = counter[pc_f_i index][1].
REQ-027 SHALL update the ex_pc_i-indexed counter on each clock edge with resolve = 1.
- taken: increment, saturating at 11
- not taken: decrement, saturating at 00
REQ-028 SHALL not bypass a same-cycle update to the read path: a fetch lookup at the index being updated returns the pre-update value.
REQ-029 SHALL assert mispredict_o = resolve & (taken_o != ex_pred_taken_i).
REQ-030 SHALL, on the edge after mispredict_o = 1, set flush_o = 1 for exactly one cycle, with redirect_pc_o as follows.
- taken_o = 1: redirect_pc_o = ex_target_i
- taken_o = 0: redirect_pc_o = ex_pc_i + 4, modulo 2^32
REQ-031 SHALL hold redirect_pc_o at its last value while flush_o = 0.
REQ-032 SHALL accept back-to-back mispredicts, producing consecutive flush pulses each carrying its own redirect PC.
REQ-033 SHALL increment br_cnt_o on every resolve and mispred_cnt_o on every mispredict; both saturate at FFFFFFFF without wrapping.

Reset
REQ-034 SHALL, while rst_i = 1 at a clock edge, reset the following state; reset SHALL take priority over any same-cycle resolve or update.
- all table counters to 01 (weakly not-taken)
- flush_o to 0, redirect_pc_o to 00000000
- br_cnt_o and mispred_cnt_o to 0
REQ-035 SHALL drop a resolve in progress when reset is asserted mid-operation, with no flush issued after reset is released.

Verification
REQ-036 SHALL verify BEQ resolve: BEQ, br_equal_i = 1, ex_pred_taken_i = 0, ex_pc_i = 00000100, ex_target_i = 00000200.
- same cycle: taken_o = 1, mispredict_o = 1
- next cycle: flush_o = 1, redirect_pc_o = 00000200
- following cycle: flush_o = 0
REQ-037 SHALL verify BGEU resolve: BGEU, br_less_i = 1, ex_pred_taken_i = 1, ex_pc_i = FFFFFFFC.
- br_unsign_o = 1, taken_o = 0
- flush pulse with redirect_pc_o = 00000000 (wrap-around)
REQ-038 SHALL verify counter saturation: after reset, three taken resolves at PC 00000010.
- pred_taken_o for pc_f_i = 00000010 reads 0 before the first update edge, then 1 after it
- counter saturates at 11
- two not-taken resolves then leave pred_taken_o = 0
REQ-039 SHALL verify illegal funct3: funct3 = 010 with ex_valid_i = 1 and ex_is_br_i = 1.
- illegal_o = 1, taken_o = 0, mispredict_o = 0
- br_cnt_o unchanged, no flush
REQ-040 SHALL verify reset priority: rst_i = 1 in the same cycle as a mispredicting resolve.
- next cycle: flush_o = 0, br_cnt_o = 0, mispred_cnt_o = 0
- all table entries predict not-taken
REQ-041 SHALL verify the ex_valid_i gate: a branch with ex_valid_i = 0 and any comparator inputs.
- taken_o = 0, no counter or table change

Source files
------------

// File: rtl/br_predict.sv
// rtl/br_predict.sv - branch resolve unit with 2-bit bimodal direction predictor
// Resolves execute-stage branches, trains the counter table, and issues a one-cycle flush on mispredict.
module br_predict #(
   parameter int IDX_W = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] pc_f_i,
   output logic        pred_taken_o,
   input  logic        ex_valid_i,
   input  logic        ex_is_br_i,
   input  logic [2:0]  ex_funct3_i,
   input  logic [31:0] ex_pc_i,
   input  logic [31:0] ex_target_i,
   input  logic        ex_pred_taken_i,
   input  logic        br_less_i,
   input  logic        br_equal_i,
   output logic        br_unsign_o,
   output logic        taken_o,
   output logic        mispredict_o,
   output logic        flush_o,
   output logic [31:0] redirect_pc_o,
   output logic        illegal_o,
   output logic [31:0] br_cnt_o,
   output logic [31:0] mispred_cnt_o
);

   localparam int N_ENT = 1 << IDX_W;

   logic             legal;
   logic             resolve;
   logic             taken;
   logic             mispredict;
   logic [IDX_W-1:0] f_idx;
   logic [IDX_W-1:0] ex_idx;
   logic             unused_pc;

   logic [1:0]  bht_q [N_ENT];
   logic [1:0]  bht_d [N_ENT];
   logic        flush_q, flush_d;
   logic [31:0] redirect_q, redirect_d;
   logic [31:0] br_cnt_q, br_cnt_d;
   logic [31:0] mispred_cnt_q, mispred_cnt_d;

   assign f_idx     = pc_f_i[IDX_W+1:2];
   assign ex_idx    = ex_pc_i[IDX_W+1:2];
   assign unused_pc = ^{pc_f_i[31:IDX_W+2], pc_f_i[1:0]};

   // funct3 010/011 have no branch encoding
   always_comb begin
      legal      = (ex_funct3_i[2:1] != 2'b01);
      resolve    = ex_valid_i & ex_is_br_i & legal;
      taken      = 1'b0;
      if (resolve) begin
         case (ex_funct3_i)
            3'b000:         taken = br_equal_i;
            3'b001:         taken = !br_equal_i;
            3'b100, 3'b110: taken = br_less_i;
            3'b101, 3'b111: taken = !br_less_i;
            default:        taken = 1'b0;
         endcase
      end
      mispredict = resolve & (taken != ex_pred_taken_i);
   end

   // Table read uses registered state only, so a same-cycle update is not visible
   assign pred_taken_o  = bht_q[f_idx][1];
   assign br_unsign_o   = ex_funct3_i[1];
   assign taken_o       = taken;
   assign mispredict_o  = mispredict;
   assign illegal_o     = ex_valid_i & ex_is_br_i & !legal;
   assign flush_o       = flush_q;
   assign redirect_pc_o = redirect_q;
   assign br_cnt_o      = br_cnt_q;
   assign mispred_cnt_o = mispred_cnt_q;

   always_comb begin
      bht_d         = bht_q;
      flush_d       = mispredict;
      redirect_d    = redirect_q;
      br_cnt_d      = br_cnt_q;
      mispred_cnt_d = mispred_cnt_q;
      if (mispredict) begin
         redirect_d = taken ? ex_target_i : (ex_pc_i + 32'd4);
      end
      if (resolve) begin
         if (taken) begin
            if (bht_q[ex_idx] != 2'b11) bht_d[ex_idx] = bht_q[ex_idx] + 2'b01;
         end else begin
            if (bht_q[ex_idx] != 2'b00) bht_d[ex_idx] = bht_q[ex_idx] - 2'b01;
         end
         if (br_cnt_q != 32'hFFFF_FFFF) br_cnt_d = br_cnt_q + 32'd1;
      end
      if (mispredict && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
         mispred_cnt_d = mispred_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < N_ENT; i++) bht_q[i] <= 2'b01;
         flush_q       <= 1'b0;
         redirect_q    <= 32'd0;
         br_cnt_q      <= 32'd0;
         mispred_cnt_q <= 32'd0;
      end else begin
         bht_q         <= bht_d;
         flush_q       <= flush_d;
         redirect_q    <= redirect_d;
         br_cnt_q      <= br_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

endmodule

// File: tb/tb_br_predict.sv
// tb/tb_br_predict.sv - directed self-checking bench for br_predict
module tb_br_predict;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] pc_f_i;
   logic        pred_taken_o;
   logic        ex_valid_i;
   logic        ex_is_br_i;
   logic [2:0]  ex_funct3_i;
   logic [31:0] ex_pc_i;
   logic [31:0] ex_target_i;
   logic        ex_pred_taken_i;
   logic        br_less_i;
   logic        br_equal_i;
   logic        br_unsign_o;
   logic        taken_o;
   logic        mispredict_o;
   logic        flush_o;
   logic [31:0] redirect_pc_o;
   logic        illegal_o;
   logic [31:0] br_cnt_o;
   logic [31:0] mispred_cnt_o;

   int n_cmp = 0;
   int n_err = 0;

   br_predict #(.IDX_W(4)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .pc_f_i         (pc_f_i),
      .pred_taken_o   (pred_taken_o),
      .ex_valid_i     (ex_valid_i),
      .ex_is_br_i     (ex_is_br_i),
      .ex_funct3_i    (ex_funct3_i),
      .ex_pc_i        (ex_pc_i),
      .ex_target_i    (ex_target_i),
      .ex_pred_taken_i(ex_pred_taken_i),
      .br_less_i      (br_less_i),
      .br_equal_i     (br_equal_i),
      .br_unsign_o    (br_unsign_o),
      .taken_o        (taken_o),
      .mispredict_o   (mispredict_o),
      .flush_o        (flush_o),
      .redirect_pc_o  (redirect_pc_o),
      .illegal_o      (illegal_o),
      .br_cnt_o       (br_cnt_o),
      .mispred_cnt_o  (mispred_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks happen 1 unit later still
   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_br(input logic [2:0] f3, input logic eq, input logic lt, input logic pt,
                         input logic [31:0] pc, input logic [31:0] tgt);
      ex_valid_i      = 1'b1;
      ex_is_br_i      = 1'b1;
      ex_funct3_i     = f3;
      br_equal_i      = eq;
      br_less_i       = lt;
      ex_pred_taken_i = pt;
      ex_pc_i         = pc;
      ex_target_i     = tgt;
   endtask

   initial begin
      rst_i = 1'b1; pc_f_i = 32'd0;
      ex_valid_i = 1'b0; ex_is_br_i = 1'b0; ex_funct3_i = 3'd0;
      ex_pc_i = 32'd0; ex_target_i = 32'd0; ex_pred_taken_i = 1'b0;
      br_less_i = 1'b0; br_equal_i = 1'b0;
      repeat (2) cyc();
      rst_i = 1'b0;
      #1;
      chk("rst_flush", flush_o, 0);
      chk("rst_redirect", redirect_pc_o, 0);
      chk("rst_br_cnt", br_cnt_o, 0);
      chk("rst_mispred_cnt", mispred_cnt_o, 0);
      chk("rst_pred", pred_taken_o, 0);

      // BEQ taken, predicted not-taken
      set_br(3'b000, 1, 0, 0, 32'h0000_0100, 32'h0000_0200);
      #1;
      chk("beq_taken", taken_o, 1);
      chk("beq_mispredict", mispredict_o, 1);
      chk("beq_illegal", illegal_o, 0);
      chk("beq_unsign", br_unsign_o, 0);
      cyc();
      ex_valid_i = 1'b0; pc_f_i = 32'h0000_0100;
      #1;
      chk("beq_flush", flush_o, 1);
      chk("beq_redirect", redirect_pc_o, 32'h0000_0200);
      chk("beq_br_cnt", br_cnt_o, 1);
      chk("beq_mispred_cnt", mispred_cnt_o, 1);
      chk("beq_pred_trained", pred_taken_o, 1);
      cyc();
      chk("beq_flush_end", flush_o, 0);
      chk("beq_redirect_hold", redirect_pc_o, 32'h0000_0200);

      // BGEU not taken, predicted taken, PC+4 wraps
      set_br(3'b111, 0, 1, 1, 32'hFFFF_FFFC, 32'h0000_0008);
      #1;
      chk("bgeu_unsign", br_unsign_o, 1);
      chk("bgeu_taken", taken_o, 0);
      chk("bgeu_mispredict", mispredict_o, 1);
      cyc();
      ex_valid_i = 1'b0;
      #1;
      chk("bgeu_flush", flush_o, 1);
      chk("bgeu_redirect", redirect_pc_o, 32'h0000_0000);
      chk("bgeu_br_cnt", br_cnt_o, 2);
      cyc();
      chk("bgeu_flush_end", flush_o, 0);

      // back-to-back mispredicts: BNE taken then BLT not taken
      set_br(3'b001, 0, 0, 0, 32'h0000_0044, 32'h0000_1000);
      #1;
      chk("b2b_bne_taken", taken_o, 1);
      cyc();
      set_br(3'b100, 0, 0, 1, 32'h0000_0088, 32'h0000_2000);
      #1;
      chk("b2b_flush1", flush_o, 1);
      chk("b2b_redirect1", redirect_pc_o, 32'h0000_1000);
      chk("b2b_blt_taken", taken_o, 0);
      chk("b2b_blt_mispredict", mispredict_o, 1);
      cyc();
      ex_valid_i = 1'b0;
      #1;
      chk("b2b_flush2", flush_o, 1);
      chk("b2b_redirect2", redirect_pc_o, 32'h0000_008C);
      chk("b2b_br_cnt", br_cnt_o, 4);
      chk("b2b_mispred_cnt", mispred_cnt_o, 4);
      cyc();
      chk("b2b_flush_end", flush_o, 0);

      // illegal funct3 010 and 011
      set_br(3'b010, 1, 1, 0, 32'h0000_0010, 32'h0000_0300);
      #1;
      chk("ill010_flag", illegal_o, 1);
      chk("ill010_taken", taken_o, 0);
      chk("ill010_mispredict", mispredict_o, 0);
      ex_funct3_i = 3'b011;
      #1;
      chk("ill011_flag", illegal_o, 1);
      chk("ill011_mispredict", mispredict_o, 0);
      cyc();
      ex_valid_i = 1'b0;
      #1;
      chk("ill_br_cnt", br_cnt_o, 4);
      chk("ill_flush", flush_o, 0);

      // valid gate: would be a taken, mispredicted BEQ if valid were high
      set_br(3'b000, 1, 1, 0, 32'h0000_0010, 32'h0000_0300);
      ex_valid_i = 1'b0; pc_f_i = 32'h0000_0010;
      #1;
      chk("nv_taken", taken_o, 0);
      chk("nv_mispredict", mispredict_o, 0);
      cyc();
      chk("nv_br_cnt", br_cnt_o, 4);
      chk("nv_flush", flush_o, 0);
      chk("nv_pred", pred_taken_o, 0);

      // reset coincides with a mispredicting resolve at an entry that was trained taken
      set_br(3'b000, 1, 0, 0, 32'h0000_0100, 32'h0000_0300);
      rst_i = 1'b1;
      cyc();
      rst_i = 1'b0; ex_valid_i = 1'b0;
      #1;
      chk("rp_flush", flush_o, 0);
      chk("rp_br_cnt", br_cnt_o, 0);
      chk("rp_mispred_cnt", mispred_cnt_o, 0);
      chk("rp_redirect", redirect_pc_o, 0);
      for (int i = 0; i < 16; i++) begin
         pc_f_i = i << 2;
         #1;
         chk($sformatf("rp_pred_%0d", i), pred_taken_o, 0);
      end
      cyc();
      chk("rp_no_late_flush", flush_o, 0);

      // saturation at PC 0x10: 01 -> 10 -> 11 -> 11, then 10 -> 01
      pc_f_i = 32'h0000_0010;
      set_br(3'b000, 1, 0, 0, 32'h0000_0010, 32'h0000_0020);
      #1;
      chk("sat_pre_update", pred_taken_o, 0);
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk($sformatf("sat_taken_%0d", k), pred_taken_o, 1);
      end
      br_equal_i = 1'b0;
      cyc();
      chk("sat_nt_1", pred_taken_o, 1);
      cyc();
      ex_valid_i = 1'b0;
      #1;
      chk("sat_nt_2", pred_taken_o, 0);
      chk("sat_br_cnt", br_cnt_o, 5);
      chk("sat_mispred_cnt", mispred_cnt_o, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
